// File: rtl/midi_cmd_mediator.sv
// midi_cmd_mediator
//   Turns a serial MIDI byte stream into 16-bit synth note commands.
//   Note On/Off messages (with running status) are parsed into words of the
//   form {on, note[6:0], 1'b0, vel[6:0]}. The words are queued in a small
//   FIFO, and each word is presented on o_data for a single clock.
//   Between commands o_data is held at zero, so each command reaches the
//   synth exactly once.
//
// Parameters
//   FIFO_DEPTH  command queue entries (power of 2, >= 2)
//   GAP_CYCLES  minimum zero cycles on o_data between two commands (0..15)
//   CHANNEL     accepted MIDI channel when OMNI = 0
//   OMNI        1: accept every channel
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   i_byte        MIDI byte from the UART receiver
//   i_byte_valid  one-cycle strobe qualifying i_byte
//   o_data        synth command, 0 when idle (registered)
//   o_overflow    one-cycle pulse: a completed command was dropped (registered)
//   o_pending     command queue non-empty
module midi_cmd_mediator #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1,
    parameter int CHANNEL    = 0,
    parameter bit OMNI       = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic [15:0] o_data,
    output logic        o_overflow,
    output logic        o_pending
);

    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH  = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  GAP_LD = 4'(GAP_CYCLES);
    localparam logic [3:0]  CHAN   = 4'(CHANNEL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_NOTE,
        S_WAIT_VEL,
        S_SKIP
    } state_t;

    // ---------------------------------------------------------------- parser
    state_t      state_q, state_d;
    logic        type_on_q, type_on_d;     // 1: Note On, 0: Note Off
    logic [6:0]  note_q, note_d;
    logic        push_q, push_d;           // completed word waiting for the FIFO
    logic [15:0] push_word_q, push_word_d;

    logic is_realtime, is_system, is_note_status, chan_ok;

    assign is_realtime    = (i_byte[7:3] == 5'b11111);          // F8..FF
    assign is_system      = (i_byte[7:3] == 5'b11110);          // F0..F7
    assign is_note_status = (i_byte[7:5] == 3'b100);            // 8n / 9n
    assign chan_ok        = OMNI || (i_byte[3:0] == CHAN);

    always_comb begin
        state_d     = state_q;
        type_on_d   = type_on_q;
        note_d      = note_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        if (i_byte_valid) begin
            if (is_realtime) begin
                // Real-time bytes may interleave anywhere; the partial
                // message in progress is left untouched.
            end else if (is_system) begin
                state_d   = S_SKIP;
                type_on_d = 1'b0;
            end else if (i_byte[7]) begin
                if (is_note_status && chan_ok) begin
                    state_d   = S_WAIT_NOTE;
                    type_on_d = i_byte[4];
                end else begin
                    state_d = S_SKIP;
                end
            end else begin
                unique case (state_q)
                    S_WAIT_NOTE: begin
                        note_d  = i_byte[6:0];
                        state_d = S_WAIT_VEL;
                    end
                    S_WAIT_VEL: begin
                        // Note On with velocity 0 is a Note Off; its velocity
                        // is already 0 so the low field passes through as-is.
                        push_d      = 1'b1;
                        push_word_d = {type_on_q && (i_byte[6:0] != 7'd0),
                                       note_q, 1'b0, i_byte[6:0]};
                        state_d     = S_WAIT_NOTE;   // running status
                    end
                    default: ;                       // IDLE / SKIP drop data
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            type_on_q   <= 1'b0;
            note_q      <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            state_q     <= state_d;
            type_on_q   <= type_on_d;
            note_q      <= note_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
        end
    end

    // ---------------------------------------------------- FIFO and issuer
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [3:0]    gap_q, gap_d;
    logic [15:0]   data_q, data_d;
    logic          ovf_q, ovf_d;
    logic          full, pop, push_ok;

    assign full    = (count_q == DEPTH);
    assign pop     = (count_q != '0) && (gap_q == 4'd0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok = push_q && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        gap_d    = gap_q;
        data_d   = 16'd0;
        ovf_d    = push_q && full && !pop;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            data_d   = mem_q[rd_ptr_q];
            gap_d    = GAP_LD;
        end else if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_word_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gap_q    <= 4'd0;
            data_q   <= 16'd0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_data     = data_q;
    assign o_overflow = ovf_q;
    assign o_pending  = (count_q != '0);

endmodule
